// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Digit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, processed DIGIT
//   bits per clock, LSB first, with a single registered borrow between digits.
//   A start/busy/done handshake lets a controlling FSM launch one operation at
//   a time; results hold until the next operation finishes.
//
//   Optional feature macro: SERIAL_SUB_OVF_EN
//     defined   -> adds the ovf port (signed overflow of the last result)
//     undefined -> no ovf port and no sign-bit storage
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Number of digits per operation and the counter that walks them.
  localparam int N  = WIDTH / ((DIGIT > 0) ? DIGIT : 1);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Reject geometries where the operand does not split into whole digits.
  if (WIDTH < 1 || DIGIT < 1) begin : g_bad_size
    $error("serial_subtractor: WIDTH and DIGIT must both be >= 1");
  end else if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operand shift registers, partial-result register, borrow and digit count.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             brw;
  logic [CW-1:0]    cnt;

  // One-digit subtract datapath.
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   dig_full;
  logic [DIGIT-1:0] d_dig;
  logic             brw_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic             last_dig;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register; synchronous reset returns to IDLE and wins over start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values;
    // a blocking = here would make later reads in the same edge see new values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE on the last digit,
  // DONE -> IDLE unconditionally. start outside IDLE is ignored.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_nxt unassigned
    // and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (last_dig) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state register, so they are
  // glitch-free and line up exactly with the RUN and DONE cycles.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // Subtract the low digit of each operand with the stored borrow. The extra
  // MSB of the (DIGIT+1)-bit difference is the borrow out of this digit.
  always_comb begin
    a_dig    = a_sh[DIGIT-1:0];
    b_dig    = b_sh[DIGIT-1:0];
    dig_full = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, brw};
    d_dig    = dig_full[DIGIT-1:0];
    brw_nxt  = dig_full[DIGIT];
    // The new digit enters at the top; after N digits the LSB digit has been
    // pushed all the way down and res_nxt is the complete difference.
    res_nxt  = WIDTH'({d_dig, res_sh} >> DIGIT);
  end

  assign last_dig = (cnt == LAST);

  // Capture operands on an accepted start, then shift one digit per RUN edge.
  // diff/bout update only on the final digit, so they hold the previous result
  // for the whole duration of a new operation.
  always_ff @(posedge clk) begin
    // NOTE: the shift registers are cleared on reset along with the control
    // state, so an aborted operation leaves no stale operand or borrow behind.
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_nxt;
          brw    <= brw_nxt;
          cnt    <= last_dig ? '0 : cnt + CW'(1);
          if (last_dig) begin
            diff <= res_nxt;
            bout <= brw_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // The operand sign bits are shifted out of a_sh/b_sh during RUN, so they are
  // kept separately for the overflow decision made on the final digit.
  logic a_sgn;
  logic b_sgn;

  // Retain sign bits on start; register ovf on the same edge as diff.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sgn <= 1'b0;
      b_sgn <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sgn <= a[WIDTH-1];
      b_sgn <= b[WIDTH-1];
    end else if (state == RUN && last_dig) begin
      ovf <= (a_sgn != b_sgn) && (res_nxt[WIDTH-1] != a_sgn);
    end
  end
`else
  // Without the overflow flag no sign information needs to be kept.
`endif

endmodule
